vic_prio_wb: RTL and testbench
==============================

// Module: vic_prio_wb
// PURPOSE
//  Parametrised vectored interrupt controller, successor to the 2-channel VIC in front of the VM1 CPU.
//  - Collects N interrupt requests: per-channel edge latch, mask and fixed priority.
//  - Drives CPU VIRQ and answers the IAKO vector-read cycle with the winner's vector over a wb-style stb/ack handshake.
//  - Pulses a per-channel acknowledge back to the requesting peripheral.
// PARAMETERS
//  N         2        number of interrupt channels (1..16); channel 0 = highest priority
//  VW        16       vector width in bits
//  SPUR_VEC  16'o0    vector returned when an IAKO cycle finds nothing pending
// PORTS
//  clk_sys    in   1      system clock
//  reset_n    in   1      synchronous reset, active low
//  ce         in   1      bus clock enable (ce_cpu_p rate); all non-reset state advances only when ce=1
//  ivec       in   N*VW   vectors, channel i at ivec[i*VW +: VW]
//  ireq       in   N      request lines, rising edge sampled at ce
//  imask      in   N      1 = channel masked (stays pending, not arbitrated)
//  iack       out  N      one-ce-cycle acknowledge pulse to the served channel
//  wb_stb_i   in   1      vector-read strobe (IAKO & !we & bus strobe)
//  wb_dat_o   out  VW     vector; 0 while wb_ack_o=0
//  wb_ack_o   out  1      reply to CPU
//  wb_irq_o   out  1      VIRQ to CPU, registered
//  pending_o  out  N      debug view of pending latches
// BEHAVIOUR
//  - Reset (reset_n=0 at any clk_sys edge, ce ignored):
//    - pending=0, ireq history=0, state=IDLE.
//    - wb_ack_o=0, wb_dat_o=0, wb_irq_o=0, iack=0.
//  - Edge latch: at ce, ireq[i]=1 with previous sample 0 sets pending[i].
//    - Level-high ireq does not re-set pending once cleared; a new rising edge is required.
//  - wb_irq_o <= |(pending & ~imask), updated each ce (1 ce latency from edge to IRQ).
//  - Arbitration: winner = lowest index i with pending[i] & ~imask[i].
//  - FSM, all transitions at ce:
//    - IDLE -> ACK when wb_stb_i=1.
//      - Latch win_idx.
//      - Latch valid = (winner exists).
//      - wb_dat_o <= valid ? ivec[win] : SPUR_VEC.
//      - wb_ack_o <= 1 (ack visible 1 ce after stb seen).
//    - ACK: hold wb_dat_o/wb_ack_o while wb_stb_i=1.
//      - On wb_stb_i=0 -> DONE: wb_ack_o<=0, wb_dat_o<=0.
//      - If valid: clear pending[win] and iack[win]<=1.
//    - DONE -> IDLE next ce; iack<=0 (pulse exactly 1 ce cycle).
//      - Stb must be seen low once before a new cycle is accepted.
//  - Latched winner is immune to later mask/ireq changes during ACK.
//  - Simultaneous new rising edge on ch i and clear of pending[i] in the same ce: set wins (pending stays 1).
//  - Spurious cycle (no winner): ack given with SPUR_VEC; no pending cleared; no iack pulse.
//  - Reset mid-ACK: aborts immediately; ack drops next clk_sys edge; no iack emitted.
//  - Masked-but-pending channels keep pending; they arbitrate once unmasked.
// CONFIGURATION
//  VIC_ROUND_ROBIN_EN defined:
//    - Rotating priority; search starts at (last_served+1) mod N, wrapping.
//    - last_served resets to N-1 and updates only on valid acks.
//  VIC_ROUND_ROBIN_EN undefined:
//    - Fixed priority, channel 0 highest.
//    - No last_served register is built.
// TESTING
//  1. Reset: reset_n=0 for 3 clk with ireq=all 1.
//     -> after release, irq=0, pending=0; needs new edges before irq.
//  2. N=2, ivec={274,60}, edge on ch1 only, then stb.
//     -> irq 1 ce after edge; ack 1 ce after stb, dat=0274.
//     -> stb low: iack=2'b10 for 1 ce, irq=0.
//  3. Edges on ch0 and ch1 same ce, two IAKO cycles.
//     -> fixed: 060 then 0274; with VIC_ROUND_ROBIN_EN and last_served=0: 0274 then 060.
//  4. imask=01, edge ch0, stb.
//     -> irq=0, dat=SPUR_VEC(0), no iack, pending=01 kept.
//     -> clearing imask raises irq next ce.
//  5. Edge ch0, stb; new ch0 edge lands on the clear ce.
//     -> pending[0]=1 remains, irq stays 1.
//  6. reset_n=0 while wb_ack_o=1.
//     -> ack/dat cleared next clk, iack never pulses, state IDLE.

Source files
------------

// File: rtl/vic_prio_wb.sv
// ----------------------------------------------------------------------------
// vic_prio_wb
//
// Parametrised vectored interrupt controller sitting in front of the VM1 CPU.
// Each request line has a rising-edge latch ("pending"), a mask bit and a
// priority. The controller raises VIRQ (wb_irq_o) while any unmasked channel
// is pending. It answers the CPU's IAKO vector-read cycle on a wb-style
// stb/ack handshake with the winning channel's vector, then sends a one
// ce-cycle acknowledge pulse back to the served peripheral.
//
// Parameters
//   N         number of channels (1..16), channel 0 is the highest priority
//   VW        vector width in bits
//   SPUR_VEC  vector returned when an IAKO cycle finds nothing eligible
//
// Ports
//   clk_sys    in   1     system clock
//   reset_n    in   1     synchronous reset, active low, independent of ce
//   ce         in   1     bus clock enable; all other state advances only at ce
//   ivec       in   N*VW  per-channel vectors, channel i at ivec[i*VW +: VW]
//   ireq       in   N     request lines, rising edge sampled at ce
//   imask      in   N     1 = channel masked (stays pending, not arbitrated)
//   iack       out  N     one ce-cycle acknowledge pulse to the served channel
//   wb_stb_i   in   1     vector-read strobe
//   wb_dat_o   out  VW    vector, 0 whenever wb_ack_o is 0
//   wb_ack_o   out  1     reply to the CPU
//   wb_irq_o   out  1     VIRQ to the CPU, registered
//   pending_o  out  N     debug view of the pending latches
//
// Build option
//   VIC_ROUND_ROBIN_EN  when defined, priority rotates: the search starts at
//                       the channel after the last one served, wrapping.
//                       When undefined, priority is fixed (channel 0 first)
//                       and no last-served register exists.
// ----------------------------------------------------------------------------
module vic_prio_wb #(
    parameter int            N        = 2,
    parameter int            VW       = 16,
    parameter logic [VW-1:0] SPUR_VEC = '0
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce,
    input  logic [N*VW-1:0] ivec,
    input  logic [N-1:0]    ireq,
    input  logic [N-1:0]    imask,
    output logic [N-1:0]    iack,
    input  logic            wb_stb_i,
    output logic [VW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_irq_o,
    output logic [N-1:0]    pending_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    pending;
    logic [N-1:0]    pending_nxt;
    logic [N-1:0]    ireq_prev;
    logic [N-1:0]    eligible;
    logic [N-1:0]    clr_vec;
    logic [N-1:0]    iack_nxt;

    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic            win_latch;

    logic            ack_nxt;
    logic [VW-1:0]   dat_nxt;

`ifdef VIC_ROUND_ROBIN_EN
    logic [IW-1:0]   last_served;
    int              rr_pos;
    logic [IW-1:0]   rr_cand;
`endif

    assign pending_o = pending;
    assign eligible  = pending & ~imask;

    // Arbitration over the unmasked pending channels. The result is only
    // consumed at the moment an IAKO cycle is accepted; afterwards the
    // latched winner (win_idx/win_valid) is used so that mask or request
    // changes during the ACK phase cannot redirect the acknowledge.
`ifdef VIC_ROUND_ROBIN_EN
    always_comb begin
        arb_idx   = '0;
        arb_valid = 1'b0;
        rr_pos    = 0;
        rr_cand   = '0;
        for (int k = 1; k <= N; k++) begin
            rr_pos  = (int'(last_served) + k) % N;
            rr_cand = IW'(rr_pos);
            if (!arb_valid && eligible[rr_cand]) begin
                arb_idx   = rr_cand;
                arb_valid = 1'b1;
            end
        end
    end
`else
    always_comb begin
        arb_idx   = '0;
        arb_valid = 1'b0;
        // Scanning downwards lets the lowest eligible index overwrite last.
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                arb_idx   = IW'(i);
                arb_valid = 1'b1;
            end
        end
    end
`endif

    // FSM state register. Reset is synchronous and overrides ce, so a cycle
    // in progress is abandoned on the very next clock edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic for the IAKO handshake. The strobe
    // must be seen low (ACK -> DONE) before another cycle can be accepted,
    // and DONE lasts exactly one ce so the iack pulse is one ce wide.
    always_comb begin
        state_nxt = state;
        ack_nxt   = wb_ack_o;
        dat_nxt   = wb_dat_o;
        iack_nxt  = '0;
        clr_vec   = '0;
        win_latch = 1'b0;
        case (state)
            IDLE: begin
                if (wb_stb_i) begin
                    state_nxt = ACK;
                    win_latch = 1'b1;
                    ack_nxt   = 1'b1;
                    dat_nxt   = arb_valid ? ivec[int'(arb_idx)*VW +: VW] : SPUR_VEC;
                end
            end
            ACK: begin
                if (!wb_stb_i) begin
                    state_nxt = DONE;
                    ack_nxt   = 1'b0;
                    dat_nxt   = '0;
                    if (win_valid) begin
                        for (int i = 0; i < N; i++) begin
                            clr_vec[i] = (win_idx == IW'(i));
                        end
                    end
                    iack_nxt = clr_vec;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
                dat_nxt   = '0;
            end
        endcase
        // A new rising edge arriving on the same ce as the clear keeps the
        // channel pending, so the OR with the edge term comes last.
        pending_nxt = (pending & ~clr_vec) | (ireq & ~ireq_prev);
    end

    // Datapath registers: pending latches, edge history, CPU-facing outputs
    // and the winner captured at the start of an IAKO cycle. VIRQ is taken
    // from the registered pending state, so it trails the latch by one ce.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pending   <= '0;
            ireq_prev <= '0;
            wb_irq_o  <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            iack      <= '0;
            win_idx   <= '0;
            win_valid <= 1'b0;
        end else if (ce) begin
            pending   <= pending_nxt;
            ireq_prev <= ireq;
            wb_irq_o  <= |eligible;
            wb_ack_o  <= ack_nxt;
            wb_dat_o  <= dat_nxt;
            iack      <= iack_nxt;
            if (win_latch) begin
                win_idx   <= arb_idx;
                win_valid <= arb_valid;
            end
        end
    end

`ifdef VIC_ROUND_ROBIN_EN
    // Rotation pointer: moves only when a real (non-spurious) cycle
    // completes, i.e. when a pending bit is actually cleared.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            last_served <= IW'(N - 1);
        end else if (ce && (|clr_vec)) begin
            last_served <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_vic_prio_wb.sv
// ----------------------------------------------------------------------------
// tb_vic_prio_wb
//
// Self-checking bench for vic_prio_wb with N=2, VW=16, SPUR_VEC=0.
// Directed scenarios check reset, single request, simultaneous requests,
// masking with a spurious cycle, set-beats-clear and reset during ACK. A
// randomized phase then compares every output against a transaction-level
// reference model kept in this file.
// ----------------------------------------------------------------------------
module tb_vic_prio_wb;

    localparam int            N    = 2;
    localparam int            VW   = 16;
    localparam logic [VW-1:0] SPUR = 16'o0;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic            ce;
    logic [N*VW-1:0] ivec;
    logic [N-1:0]    ireq;
    logic [N-1:0]    imask;
    logic [N-1:0]    iack;
    logic            wb_stb_i;
    logic [VW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_irq_o;
    logic [N-1:0]    pending_o;

    int checks = 0;
    int passed = 0;

    vic_prio_wb #(.N(N), .VW(VW), .SPUR_VEC(SPUR)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce        (ce),
        .ivec      (ivec),
        .ireq      (ireq),
        .imask     (imask),
        .iack      (iack),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_irq_o  (wb_irq_o),
        .pending_o (pending_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: one transaction at a time. m_busy marks an accepted
    // vector read still holding ack, m_cool the mandatory idle ce after it.
    logic [N-1:0]  m_pending, m_prev, m_iack;
    logic          m_irq, m_ack;
    logic [VW-1:0] m_dat;
    bit            m_busy, m_cool;
    int            m_served;
    int            m_last;

    function automatic logic [VW-1:0] vec_of(int i);
        return ivec[i*VW +: VW];
    endfunction

    function automatic int pick(logic [N-1:0] elig);
`ifdef VIC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (elig[c]) return c;
        end
`else
        for (int c = 0; c < N; c++) begin
            if (elig[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_update();
        logic [N-1:0] elig;
        logic [N-1:0] kept;
        if (!reset_n) begin
            m_pending = '0; m_prev = '0; m_iack = '0;
            m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;
            m_busy = 1'b0; m_cool = 1'b0; m_served = -1; m_last = N - 1;
        end else if (ce) begin
            elig   = m_pending & ~imask;
            kept   = m_pending;
            m_iack = '0;
            if (m_busy) begin
                if (!wb_stb_i) begin
                    m_busy = 1'b0; m_cool = 1'b1; m_ack = 1'b0; m_dat = '0;
                    if (m_served >= 0) begin
                        kept[m_served]   = 1'b0;
                        m_iack[m_served] = 1'b1;
                        m_last           = m_served;
                    end
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (wb_stb_i) begin
                m_served = pick(elig);
                m_busy   = 1'b1;
                m_ack    = 1'b1;
                m_dat    = (m_served >= 0) ? vec_of(m_served) : SPUR;
            end
            m_pending = kept | (ireq & ~m_prev);
            m_prev    = ireq;
            m_irq     = |elig;
        end
    endtask

    // One clock: model advances with the DUT edge, outputs sampled at negedge.
    task automatic tick();
        @(posedge clk_sys);
        model_update();
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ireq = 2'b11; ce = 1'b1;
        repeat (3) tick();
        checks++; if (wb_ack_o !== 1'b0) $display("[TB] FAIL reset_ack got=%b want=0", wb_ack_o); else passed++;
        checks++; if (wb_dat_o !== 16'd0) $display("[TB] FAIL reset_dat got=%o want=0", wb_dat_o); else passed++;
        checks++; if (wb_irq_o !== 1'b0) $display("[TB] FAIL reset_irq got=%b want=0", wb_irq_o); else passed++;
        checks++; if (iack !== 2'b00) $display("[TB] FAIL reset_iack got=%b want=00", iack); else passed++;
        checks++; if (pending_o !== 2'b00) $display("[TB] FAIL reset_pending got=%b want=00", pending_o); else passed++;
        reset_n = 1'b1; ce = 1'b0;
        tick();
        checks++; if (pending_o !== 2'b00) $display("[TB] FAIL release_pending got=%b want=00", pending_o); else passed++;
        ireq = 2'b00; ce = 1'b1;
        tick();
        checks++; if (wb_irq_o !== 1'b0) $display("[TB] FAIL release_irq got=%b want=0", wb_irq_o); else passed++;
    endtask

    task automatic test_single();
        ireq = 2'b10;
        tick();
        checks++; if (pending_o !== 2'b10) $display("[TB] FAIL single_pending got=%b want=10", pending_o); else passed++;
        tick();
        checks++; if (wb_irq_o !== 1'b1) $display("[TB] FAIL single_irq got=%b want=1", wb_irq_o); else passed++;
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_ack_o !== 1'b1) $display("[TB] FAIL single_ack got=%b want=1", wb_ack_o); else passed++;
        checks++; if (wb_dat_o !== 16'o274) $display("[TB] FAIL single_dat got=%o want=274", wb_dat_o); else passed++;
        tick();
        checks++; if (wb_dat_o !== 16'o274 || wb_ack_o !== 1'b1) $display("[TB] FAIL single_hold got=%o/%b want=274/1", wb_dat_o, wb_ack_o); else passed++;
        wb_stb_i = 1'b0;
        tick();
        checks++; if (iack !== 2'b10) $display("[TB] FAIL single_iack got=%b want=10", iack); else passed++;
        checks++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 16'd0) $display("[TB] FAIL single_release got=%o/%b want=0/0", wb_dat_o, wb_ack_o); else passed++;
        tick();
        checks++; if (iack !== 2'b00) $display("[TB] FAIL single_iack_end got=%b want=00", iack); else passed++;
        checks++; if (wb_irq_o !== 1'b0) $display("[TB] FAIL single_irq_end got=%b want=0", wb_irq_o); else passed++;
        checks++; if (pending_o !== 2'b00) $display("[TB] FAIL single_level got=%b want=00", pending_o); else passed++;
        ireq = 2'b00;
        tick();
        // Edge presented and withdrawn while ce is low must not be latched.
        ce = 1'b0; ireq = 2'b01;
        tick();
        ireq = 2'b00; ce = 1'b1;
        tick();
        checks++; if (pending_o !== 2'b00) $display("[TB] FAIL ce_gate got=%b want=00", pending_o); else passed++;
    endtask

    task automatic test_priority();
        ireq = 2'b11;
        tick();
        tick();
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_dat_o !== 16'o60) $display("[TB] FAIL prio_first got=%o want=60", wb_dat_o); else passed++;
        wb_stb_i = 1'b0;
        tick();
        checks++; if (iack !== 2'b01 || pending_o !== 2'b10) $display("[TB] FAIL prio_first_ack got=%b/%b want=01/10", iack, pending_o); else passed++;
        tick();
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_dat_o !== 16'o274) $display("[TB] FAIL prio_second got=%o want=274", wb_dat_o); else passed++;
        wb_stb_i = 1'b0;
        tick();
        checks++; if (iack !== 2'b10 || pending_o !== 2'b00) $display("[TB] FAIL prio_second_ack got=%b/%b want=10/00", iack, pending_o); else passed++;
        tick();
        ireq = 2'b00;
        tick();
    endtask

    task automatic test_mask();
        imask = 2'b01; ireq = 2'b01;
        tick();
        tick();
        checks++; if (wb_irq_o !== 1'b0) $display("[TB] FAIL mask_irq got=%b want=0", wb_irq_o); else passed++;
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== SPUR) $display("[TB] FAIL mask_spur got=%o/%b want=0/1", wb_dat_o, wb_ack_o); else passed++;
        wb_stb_i = 1'b0;
        tick();
        checks++; if (iack !== 2'b00 || pending_o !== 2'b01) $display("[TB] FAIL mask_keep got=%b/%b want=00/01", iack, pending_o); else passed++;
        tick();
        imask = 2'b00;
        tick();
        checks++; if (wb_irq_o !== 1'b1) $display("[TB] FAIL unmask_irq got=%b want=1", wb_irq_o); else passed++;
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_dat_o !== 16'o60) $display("[TB] FAIL unmask_dat got=%o want=60", wb_dat_o); else passed++;
        wb_stb_i = 1'b0;
        tick();
        tick();
        ireq = 2'b00;
        tick();
        checks++; if (pending_o !== 2'b00) $display("[TB] FAIL unmask_clear got=%b want=00", pending_o); else passed++;
    endtask

    task automatic test_set_wins();
        ireq = 2'b01;
        tick();
        ireq = 2'b00;
        tick();
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_dat_o !== 16'o60) $display("[TB] FAIL setwin_dat got=%o want=60", wb_dat_o); else passed++;
        wb_stb_i = 1'b0; ireq = 2'b01;
        tick();
        checks++; if (iack !== 2'b01 || pending_o !== 2'b01) $display("[TB] FAIL setwin_pending got=%b/%b want=01/01", iack, pending_o); else passed++;
        tick();
        checks++; if (wb_irq_o !== 1'b1) $display("[TB] FAIL setwin_irq got=%b want=1", wb_irq_o); else passed++;
        ireq = 2'b00; wb_stb_i = 1'b1;
        tick();
        wb_stb_i = 1'b0;
        tick();
        tick();
        checks++; if (pending_o !== 2'b00) $display("[TB] FAIL setwin_cleanup got=%b want=00", pending_o); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_ack();
        ireq = 2'b10;
        tick();
        ireq = 2'b00;
        tick();
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_ack_o !== 1'b1) $display("[TB] FAIL midack_ack got=%b want=1", wb_ack_o); else passed++;
        reset_n = 1'b0;
        tick();
        checks++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 16'd0) $display("[TB] FAIL midack_abort got=%o/%b want=0/0", wb_dat_o, wb_ack_o); else passed++;
        checks++; if (iack !== 2'b00 || pending_o !== 2'b00) $display("[TB] FAIL midack_state got=%b/%b want=00/00", iack, pending_o); else passed++;
        reset_n = 1'b1; wb_stb_i = 1'b0;
        tick();
        checks++; if (iack !== 2'b00) $display("[TB] FAIL midack_noiack got=%b want=00", iack); else passed++;
        wb_stb_i = 1'b1;
        tick();
        checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== SPUR) $display("[TB] FAIL midack_idle got=%o/%b want=0/1", wb_dat_o, wb_ack_o); else passed++;
        wb_stb_i = 1'b0;
        tick();
        checks++; if (iack !== 2'b00) $display("[TB] FAIL midack_spur_iack got=%b want=00", iack); else passed++;
        tick();
    endtask

    task automatic test_random();
        ivec = {$urandom_range(0, 65535), $urandom_range(0, 65535)};
        imask = 2'b00; ireq = 2'b00; wb_stb_i = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset_n = ($urandom_range(0, 149) != 0);
            ce      = ($urandom_range(0, 4) != 0);
            ireq    = N'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) imask = N'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) wb_stb_i = ~wb_stb_i;
            tick();
            checks++; if (wb_ack_o !== m_ack) $display("[TB] FAIL rnd_ack cyc=%0d got=%b want=%b", cyc, wb_ack_o, m_ack); else passed++;
            checks++; if (wb_dat_o !== m_dat) $display("[TB] FAIL rnd_dat cyc=%0d got=%h want=%h", cyc, wb_dat_o, m_dat); else passed++;
            checks++; if (wb_irq_o !== m_irq) $display("[TB] FAIL rnd_irq cyc=%0d got=%b want=%b", cyc, wb_irq_o, m_irq); else passed++;
            checks++; if (iack !== m_iack) $display("[TB] FAIL rnd_iack cyc=%0d got=%b want=%b", cyc, iack, m_iack); else passed++;
            checks++; if (pending_o !== m_pending) $display("[TB] FAIL rnd_pending cyc=%0d got=%b want=%b", cyc, pending_o, m_pending); else passed++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b0;
        ireq     = '0;
        imask    = '0;
        wb_stb_i = 1'b0;
        ivec     = {16'o274, 16'o60};
        m_served = -1;
        m_last   = N - 1;
        $display("[TB] vic_prio_wb bench start");
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_set_wins();
        test_reset_mid_ack();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
